alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Instruction-side controller for the 16-bit datapath ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU's A, B and 4-bit function-code inputs, then captures the ALU result and carry-out.
- Writes the result back to the register file, updates Z/N/C flags and signals completion. It is the consumer/driver end of the ALU interface.

Parameters:
- WIDTH, 16, datapath/register width; must match the ALU operand width.
- NREGS, 8, register-file depth; register fields are 3 bits wide.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- instr_valid  input  1  instruction word present.
- instr_ready  output  1  sequencer can accept an instruction.
- instr  input  16  [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored; for LDI, [7:0] is imm8.
- alu_a  output  16  ALU operand A.
- alu_b  output  16  ALU operand B.
- alu_fc  output  4  ALU function code.
- alu_result  input  16  ALU result (combinational from alu_a/alu_b/alu_fc).
- alu_cout  input  1  ALU carry-out.
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  one-cycle pulse, coincident with done, for op 1110/1111.
- flag_z, flag_n, flag_c  output  1 each  status flags.
- dbg_addr  input  3  register-file debug read address.
- dbg_data  output  16  combinational read of R[dbg_addr].

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - R0..R7=0.
  - alu_a=alu_b=0, alu_fc=0000.
  - done=illegal=0.
  - flag_z=flag_n=flag_c=0.
  - instr_ready=0 while rst=1.
- Reset asserted mid-instruction aborts it: no register or flag write, no done.
- FSM IDLE -> EXEC -> WB -> IDLE. Throughput is one instruction per 3 cycles.
- instr_ready = (state==IDLE) && !rst. An instruction is accepted when instr_valid && instr_ready at an edge.
- On accept (IDLE->EXEC), the following are registered:
  - op and rd.
  - alu_a <= R[ra], alu_b <= R[rb].
  - alu_fc <= op for op 0000-1100, else 0000.
- Operands are snapshot at accept; the write of the previous instruction has already completed, so there is no hazard.
- EXEC (one cycle): alu_a/alu_b/alu_fc stable; at the end edge, alu_result and alu_cout are latched into res/cy. Outputs hold their values in WB and IDLE until the next accept.
- WB (one cycle): done=1.
  - op 0000-1100: R[rd] <= res; Z <= (res==0); N <= res[15]. C <= cy only for arithmetic ops 0001-0110; otherwise C holds.
  - op 1101 (LDI): R[rd] <= {8'h00, imm8}; Z and N updated from the loaded value; C holds. The ALU value is ignored.
  - op 1110/1111: no register or flag write; illegal=1.
- Flags and the register write become visible in the cycle after WB. dbg_data reflects the new value from then on.
- rd==ra or rd==rb is legal: the old value is used as the operand and the new value is written.
- All 8 registers are writable, including R0.
- instr_valid during EXEC/WB is ignored (not accepted). The upstream block holds the instruction until instr_ready.
- Arithmetic is modulo 2^16. Carry comes only from alu_cout; the sequencer does no arithmetic of its own.

Test Plan:
- Reset then LDI R1,0x05; LDI R2,0x03; op 0010 rd=3 ra=1 rb=2 -> alu_fc=0010, alu_a=5, alu_b=3 in EXEC; R3=0x0008, done each WB, Z=0 N=0.
- LDI R1,0xFF; op 1011 (NOT) rd=4 ra=1 -> R4=0xFF00, N=1, Z=0; C unchanged from its prior value.
- Force alu_cout=1 with op 0010 (R5=R6+R7, 0xFFFF+0x0001 via two LDI plus an OR-shift setup) -> R5=0x0000, Z=1, C=1. A following op 1000 (AND) leaves C=1.
- op 1110 rd=1 -> done=1 and illegal=1 in the same cycle; R1 and flags unchanged; alu_fc=0000 in EXEC.
- Hold instr_valid=1 continuously with 3 instructions -> instr_ready high only in IDLE; accepts spaced exactly 3 cycles; three done pulses.
- Assert rst during EXEC of op 0010 rd=2 -> R2 stays 0, no done, instr_ready=0 during rst and 1 the cycle after rst drops.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake plus ALU operand/result bus between the sequencer and its neighbours.
// The sequencer takes the slave end; upstream issuer and ALU together form the master end.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic [15:0]      instr;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_fc;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;

  modport slave (
    input  instr_valid, instr, alu_result, alu_cout,
    output instr_ready, alu_a, alu_b, alu_fc
  );

  modport master (
    output instr_valid, instr, alu_result, alu_cout,
    input  instr_ready, alu_a, alu_b, alu_fc
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Instruction sequencer for the 16-bit ALU: fetches operands from an 8-entry register file,
// drives the ALU for one cycle, then writes back the result and Z/N/C flags.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_op_sequencer_if.slave        bus,
  output logic                     done,
  output logic                     illegal,
  output logic                     flag_z,
  output logic                     flag_n,
  output logic                     flag_c,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);
  localparam int RW = $clog2(NREGS);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_ready;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [3:0]       r_op;
  logic [RW-1:0]    r_rd;
  logic [7:0]       r_imm;
  logic [WIDTH-1:0] r_res;
  logic             r_cy;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_fc;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_c;

  logic [3:0]       w_op;
  logic [RW-1:0]    w_rd;
  logic [RW-1:0]    w_ra;
  logic [RW-1:0]    w_rb;
  logic [WIDTH-1:0] w_wb_val;
  logic             w_wb_en;
  logic             w_arith;

  assign w_op = bus.instr[15:12];
  assign w_rd = bus.instr[9 +: RW];
  assign w_ra = bus.instr[6 +: RW];
  assign w_rb = bus.instr[3 +: RW];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = !rst;
        if (bus.instr_valid && !rst) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = WB;
      WB: begin
        // Gated by rst so an aborted instruction never signals retirement.
        done        = !rst;
        illegal     = !rst && (r_op[3:1] == 3'b111);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // LDI (1101) bypasses the ALU result; 1110/1111 write nothing.
  assign w_wb_val = (r_op == 4'hD) ? {{(WIDTH-8){1'b0}}, r_imm} : r_res;
  assign w_wb_en  = (r_op <= 4'hD);
  assign w_arith  = (r_op >= 4'h1) && (r_op <= 4'h6);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_res    <= '0;
      r_cy     <= 1'b0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_fc <= '0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= w_op;
        r_rd     <= w_rd;
        r_imm    <= bus.instr[7:0];
        r_alu_a  <= r_regs[w_ra];
        r_alu_b  <= r_regs[w_rb];
        r_alu_fc <= (w_op <= 4'hC) ? w_op : 4'h0;
      end
      if (r_state == EXEC) begin
        r_res <= bus.alu_result;
        r_cy  <= bus.alu_cout;
      end
      if (r_state == WB && w_wb_en) begin
        r_regs[r_rd] <= w_wb_val;
        r_flag_z     <= (w_wb_val == '0);
        r_flag_n     <= w_wb_val[WIDTH-1];
        if (w_arith) r_flag_c <= r_cy;
      end
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_fc      = r_alu_fc;
  assign flag_z          = r_flag_z;
  assign flag_n          = r_flag_n;
  assign flag_c          = r_flag_c;
  assign dbg_data        = r_regs[dbg_addr];
endmodule
